oserdes_pattern_gen: RTL
========================

Name: oserdes_pattern_gen

Overview:
- Upstream stimulus stage for the OSERDES minitest.
- Produces a parallel word for the OSERDES D inputs, plus a bit-exact serial copy of the same data as the reference stream for the downstream bitstream comparator.
- Supports PRBS and deterministic patterns.
- Supports deliberate single-bit error injection on the reference path, so the comparator's error detection can be exercised on hardware.

Parameters:
- WIDTH, 8, OSERDES word width in bits; legal 2..8.
- SEED15, 15'h7FFF, PRBS15 reset seed; must be non-zero.

Ports:
- CLK  input  1  single clock; serial bit rate equals CLK rate.
- RST_N  input  1  asynchronous, active-low reset.
- I_EN  input  1  run enable; low freezes the whole block.
- I_MODE  input  2  pattern: 0 PRBS7, 1 PRBS15, 2 alternating, 3 counter.
- I_INJ_ERR  input  1  error-inject request pulse (optional feature only).
- O_DAT_PAR  output  WIDTH  parallel word for OSERDES; bit0 is serialized first.
- O_STB  output  1  one-cycle strobe: new O_DAT_PAR valid this cycle.
- O_DAT_REF  output  1  serial reference bit stream.

Behaviour:
- Reset (asynchronous assert, synchronous deassert expected upstream):
  - Outputs: O_DAT_PAR=0, O_STB=0, O_DAT_REF=0.
  - Internal state: bit counter=WIDTH-1, PRBS7 state=7'h7F, PRBS15 state=SEED15, counter pattern=0, latched mode=0, inject-pending=0.
- Word timing:
  - Bit counter runs 0..WIDTH-1 and advances only when I_EN=1.
  - At the edge where the counter wraps (WIDTH-1 -> 0), do all of the following in that same edge: load the next word into O_DAT_PAR and the internal shift register; pulse O_STB; set O_DAT_REF to word bit0.
  - On each of the following WIDTH-1 enabled edges, O_DAT_REF takes bits 1..WIDTH-1 in order.
  - Result: the first enabled edge after reset delivers word 0 with O_STB=1. O_STB period is exactly WIDTH enabled cycles.
- Mode handling:
  - I_MODE is sampled only at the wrap edge and takes effect for the word loaded on that edge.
  - A mid-word change never corrupts the current word.
- Pattern generation:
  - PRBS7: x^7+x^6+1; per step new = s[6]^s[5], state shifts left with new bit in LSB. Output bit = new bit.
  - PRBS15: x^15+x^14+1, same convention.
  - Each word consumes WIDTH consecutive steps (unrolled combinationally); first step goes to bit0.
  - Both LFSRs advance only when their mode is selected, so each sequence is continuous across word boundaries within a mode.
  - Alternating: every word = {WIDTH/2{2'b01}} (bit0=1), truncated to WIDTH when WIDTH is odd.
  - Counter: word = counter value mod 2^WIDTH, then counter increments. Wrap from all-ones to 0 is silent.
- I_EN=0:
  - Bit counter, LFSRs and shift register all hold.
  - O_STB=0; O_DAT_PAR and O_DAT_REF hold.
  - Disabling mid-word freezes at the current bit; re-enabling resumes at the next bit with no skipped or repeated bits.
- Reset mid-word: abandons the word immediately; outputs go to reset values.
- Latency: O_DAT_REF bit k of a word appears k enabled cycles after its O_STB edge. Downstream logic absorbs the OSERDES pipeline delay.

Optional Feature:
- Macro: PATTERN_GEN_ERR_INJECT_EN.
- Defined:
  - I_INJ_ERR high sets inject-pending. It is ignored if inject-pending is already set.
  - The next O_DAT_REF bit driven after pending is set is inverted, then pending clears.
  - O_DAT_PAR is never affected.
  - An inject request on the same edge as reset is lost.
  - Inject-pending holds while I_EN=0.
- Not defined: I_INJ_ERR port still exists but is ignored; no pending register; O_DAT_REF always equals the serialized O_DAT_PAR.

Decomposition:
- Shared package oserdes_pkg holds:
  - mode encoding constants MODE_PRBS7=2'd0, MODE_PRBS15=2'd1, MODE_ALT=2'd2, MODE_CNT=2'd3;
  - PRBS7 and PRBS15 tap constants;
  - default seeds.
- Sub-module prbs_word (parameters POLY length, taps, WIDTH; step enable) returns the next WIDTH-bit word and next state. It is instantiated twice, once for PRBS7 and once for PRBS15.

Test Plan:
- Reset release, I_EN=1, MODE=0, WIDTH=8 -> first O_STB on first edge with O_DAT_PAR=8'h40; O_DAT_REF over 8 cycles = 0,0,0,0,0,0,1,0; O_STB every 8 cycles; 127-bit period matches software PRBS7 model for 1000 words.
- MODE=2 then MODE=3 switched mid-word -> current word finishes unchanged; next words 8'h55 in ALT mode; in counter mode 8'h00, 8'h01, 8'h02, and 8'hFF->8'h00 wrap after 256 words.
- I_EN dropped for 5 cycles at bit 3 of a word -> outputs frozen, no O_STB; after re-enable the serial stream continues at bit 4 with no gap in the bit sequence.
- RST_N asserted asynchronously mid-word (between edges) -> outputs 0 immediately; after release, word 0 sequence repeats exactly as in the first scenario.
- With PATTERN_GEN_ERR_INJECT_EN: two I_INJ_ERR pulses 1 cycle apart -> exactly one O_DAT_REF bit inverted versus serialized O_DAT_PAR, O_DAT_PAR unchanged. Without the macro -> zero mismatches.
- MODE=1, SEED15 default, WIDTH=4 -> serial stream matches software PRBS15 model over 40000 bits; O_STB period 4.

Source files
------------

// File: rtl/oserdes_pkg.sv
// rtl/oserdes_pkg.sv - mode encodings, LFSR taps and default seeds for the OSERDES pattern generator
package oserdes_pkg;

  localparam logic [1:0] MODE_PRBS7  = 2'd0;
  localparam logic [1:0] MODE_PRBS15 = 2'd1;
  localparam logic [1:0] MODE_ALT    = 2'd2;
  localparam logic [1:0] MODE_CNT    = 2'd3;

  // x^7+x^6+1 and x^15+x^14+1: feedback taps are the two MSBs of each state
  localparam int PRBS7_LEN    = 7;
  localparam int PRBS7_TAP_A  = 6;
  localparam int PRBS7_TAP_B  = 5;
  localparam int PRBS15_LEN   = 15;
  localparam int PRBS15_TAP_A = 14;
  localparam int PRBS15_TAP_B = 13;

  localparam logic [6:0]  PRBS7_SEED  = 7'h7F;
  localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

  // bit0=1 alternating pattern; narrower words take the low bits
  localparam logic [7:0] ALT_WORD8 = 8'h55;

endpackage

// File: rtl/prbs_word.sv
// rtl/prbs_word.sv - unrolled Fibonacci LFSR producing WIDTH steps per call, first step in bit0
module prbs_word #(
  parameter int POLY_LEN = 7,
  parameter int TAP_A    = 6,
  parameter int TAP_B    = 5,
  parameter int WIDTH    = 8
) (
  input  logic [POLY_LEN-1:0] i_state,
  input  logic                i_step_en,
  output logic [WIDTH-1:0]    o_word,
  output logic [POLY_LEN-1:0] o_next_state
);

  logic [POLY_LEN-1:0] w_s;
  logic                w_new;

  always_comb begin
    w_s    = i_state;
    w_new  = 1'b0;
    o_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_new     = w_s[TAP_A] ^ w_s[TAP_B];
      o_word[i] = w_new;
      w_s       = {w_s[POLY_LEN-2:0], w_new};
    end
    o_next_state = i_step_en ? w_s : i_state;
  end

endmodule

// File: rtl/oserdes_pattern_gen.sv
// rtl/oserdes_pattern_gen.sv - OSERDES parallel word + serial reference generator; optional PATTERN_GEN_ERR_INJECT_EN
module oserdes_pattern_gen
  import oserdes_pkg::*;
#(
  parameter int          WIDTH  = 8,
  parameter logic [14:0] SEED15 = PRBS15_SEED
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             I_EN,
  input  logic [1:0]       I_MODE,
  input  logic             I_INJ_ERR,
  output logic [WIDTH-1:0] O_DAT_PAR,
  output logic             O_STB,
  output logic             O_DAT_REF
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]     r_bit_cnt;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  r_dat_par;
  logic [WIDTH-1:0]  r_cnt;
  logic [6:0]        r_prbs7;
  logic [14:0]       r_prbs15;
  logic              r_stb;
  logic              r_dat_ref;

  logic              w_wrap;
  logic [WIDTH-1:0]  w_word;
  logic [WIDTH-1:0]  w_p7_word;
  logic [WIDTH-1:0]  w_p15_word;
  logic [6:0]        w_p7_next;
  logic [14:0]       w_p15_next;
  logic              w_next_bit;
  logic              w_flip;

  assign w_wrap = I_EN && (r_bit_cnt == LAST);

  prbs_word #(
    .POLY_LEN(PRBS7_LEN), .TAP_A(PRBS7_TAP_A), .TAP_B(PRBS7_TAP_B), .WIDTH(WIDTH)
  ) u_prbs7 (
    .i_state(r_prbs7), .i_step_en(w_wrap && (I_MODE == MODE_PRBS7)),
    .o_word(w_p7_word), .o_next_state(w_p7_next)
  );

  prbs_word #(
    .POLY_LEN(PRBS15_LEN), .TAP_A(PRBS15_TAP_A), .TAP_B(PRBS15_TAP_B), .WIDTH(WIDTH)
  ) u_prbs15 (
    .i_state(r_prbs15), .i_step_en(w_wrap && (I_MODE == MODE_PRBS15)),
    .o_word(w_p15_word), .o_next_state(w_p15_next)
  );

  always_comb begin
    w_word = '0;
    case (I_MODE)
      MODE_PRBS7:  w_word = w_p7_word;
      MODE_PRBS15: w_word = w_p15_word;
      MODE_ALT:    w_word = ALT_WORD8[WIDTH-1:0];
      MODE_CNT:    w_word = r_cnt;
      default:     w_word = '0;
    endcase
  end

  assign w_next_bit = w_wrap ? w_word[0] : r_shift[0];

`ifdef PATTERN_GEN_ERR_INJECT_EN
  logic r_inj_pend;

  // the pending flag is consumed by the next driven reference bit; requests are ignored while it is set
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_inj_pend <= 1'b0;
    end else if (I_EN && r_inj_pend) begin
      r_inj_pend <= 1'b0;
    end else if (I_INJ_ERR) begin
      r_inj_pend <= 1'b1;
    end
  end

  assign w_flip = r_inj_pend;
`else
  logic w_unused_inj;
  assign w_unused_inj = I_INJ_ERR;
  assign w_flip       = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bit_cnt <= LAST;
      r_shift   <= '0;
      r_dat_par <= '0;
      r_cnt     <= '0;
      r_prbs7   <= PRBS7_SEED;
      r_prbs15  <= SEED15;
      r_stb     <= 1'b0;
      r_dat_ref <= 1'b0;
    end else begin
      r_stb    <= 1'b0;
      r_prbs7  <= w_p7_next;
      r_prbs15 <= w_p15_next;
      if (I_EN) begin
        r_dat_ref <= w_next_bit ^ w_flip;
        if (w_wrap) begin
          r_bit_cnt <= '0;
          r_dat_par <= w_word;
          r_shift   <= {1'b0, w_word[WIDTH-1:1]};
          r_stb     <= 1'b1;
          if (I_MODE == MODE_CNT) r_cnt <= r_cnt + WIDTH'(1);
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
          r_shift   <= {1'b0, r_shift[WIDTH-1:1]};
        end
      end
    end
  end

  assign O_DAT_PAR = r_dat_par;
  assign O_STB     = r_stb;
  assign O_DAT_REF = r_dat_ref;

endmodule
